i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- I2S master transmitter at the output end of the audio path. Accepts one stereo pair of 16-bit two's-complement samples per frame over a valid/ready handshake (e.g. IIR filter audio_out on both channels).
- Generates BCLK and LRCLK from the system clock. Drives SDATA in Philips I2S format: MSB first, one BCLK delay after each LRCLK edge.
- Its LRCLK output is the lr_clk that paces the upstream filter state machine.

Parameters:
- DATA_W, 16: sample width in bits.
- SLOT_W, 32: BCLK periods per channel slot. Must satisfy SLOT_W >= DATA_W.
- BCLK_DIV, 4: state_clk cycles per BCLK half-period. Must be >= 1.

Ports:
- state_clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_left  in  DATA_W  left sample, two's complement.
- in_right  in  DATA_W  right sample, two's complement.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  holding register empty; pair accepted when in_valid && in_ready.
- bclk  out  1  I2S bit clock.
- lr_clk  out  1  I2S word select; 0 = left slot, 1 = right slot.
- sdata  out  1  I2S serial data.
- frame_start  out  1  one-cycle pulse when a new frame is loaded.
- underrun  out  1  one-cycle pulse when a frame is loaded with no sample pair held.

Behaviour:
- Reset (reset_n=0 at a state_clk edge), values on the next edge:
  - bclk=0, lr_clk=1, sdata=0, frame_start=0, underrun=0, in_ready=1.
  - div_cnt=0, bit_cnt=2*SLOT_W-1, frame shift register sr=0, hold_full=0.
- Reset mid-frame discards the held pair and the frame in flight.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps; bclk toggles on the cycle div_cnt==BCLK_DIV-1.
  - BCLK period = 2*BCLK_DIV state_clk cycles.
  - Rise event: terminal count with bclk==0. Fall event: terminal count with bclk==1.
- On a fall event only, registered in the same cycle as bclk goes low:
  - bit_cnt <= (bit_cnt==2*SLOT_W-1) ? 0 : bit_cnt+1.
  - lr_clk <= (new bit_cnt >= SLOT_W).
  - sdata <= sr[2*SLOT_W-1] (always the old MSB).
  - Wrap (new bit_cnt==0): sr <= frame and frame_start=1. Otherwise sr <= sr<<1 with zero fill.
- Frame word, 2*SLOT_W bits, MSB first:
  - hold_left, then SLOT_W-DATA_W zeros, then hold_right, then SLOT_W-DATA_W zeros.
  - If hold_full=0 at the wrap, the frame is all zeros and underrun=1 for that cycle.
- One-bit delay: the left MSB appears on the first fall after lr_clk goes low. The last frame bit (the right LSB when SLOT_W==DATA_W) appears on the fall where lr_clk goes low for the next frame.
- Downstream samples sdata on bclk rising edges; sdata and lr_clk change only on fall events.
- Handshake:
  - in_ready = ~hold_full (combinational from the register).
  - Accept: latch hold_left/hold_right, hold_full<=1.
  - At a wrap with hold_full=1: the pair moves into sr and hold_full<=0; in_ready returns high the next cycle.
  - Accept in the same cycle as a wrap with hold_full=0: the pair goes to the holding register, the current frame is zeros (underrun pulses), and the pair is sent on the next frame. There is no bypass.
- in_left/in_right are ignored when in_valid=0 or in_ready=0. The held pair is never overwritten.
- frame_start and underrun are high for exactly one state_clk cycle per frame at most.
- After reset the first fall event occurs at the 2*BCLK_DIV-th edge; it wraps bit_cnt to 0 and loads the first frame.

Test Plan:
- Defaults, push L=16'hA5F0 R=16'h0F0F before the first frame -> sampled on bclk rise:
  - left slot bits 1..16 = A5F0 MSB first, bits 17..31 = 0;
  - right slot bits 1..16 = 0F0F, rest 0;
  - lr_clk low for 32 BCLKs, then high for 32.
- No input for 3 frames -> sdata constantly 0; underrun and frame_start each pulse once every 64 BCLKs (512 state_clk cycles at BCLK_DIV=4).
- SLOT_W=16, DATA_W=16, L=16'h8001 R=16'h8001 -> right LSB (1) appears on the bit where lr_clk has just returned low, before the next left MSB.
- Back-to-back pushes P1 then P2 -> in_ready low after P1 until the frame loads P1. P2 is accepted the following cycle and sent in the next frame, with no underrun between them.
- reset_n low for 1 cycle mid right slot with a pair held -> next cycle bclk=0, lr_clk=1, sdata=0, in_ready=1. The held pair is never transmitted; the first subsequent frame is zeros with underrun.
- BCLK_DIV=1 -> bclk toggles every state_clk cycle; a frame spans 128 cycles; the data pattern matches the first scenario.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master transmitter: BCLK/LRCLK generation and Philips-format serial data
module i2s_tx_serializer #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              state_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lr_clk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] frame_word;
  logic [SLOT_W-1:0]  left_slot;
  logic [SLOT_W-1:0]  right_slot;
  logic [DATA_W-1:0]  hold_left;
  logic [DATA_W-1:0]  hold_right;
  logic               hold_full;
  logic               div_tc;
  logic               fall_evt;
  logic               wrap;
  logic               accept;

  assign div_tc      = (div_cnt == DIV_LAST);
  assign fall_evt    = div_tc && bclk;
  assign bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
  assign wrap        = fall_evt && (bit_cnt_nxt == '0);
  assign in_ready    = ~hold_full;
  assign accept      = in_valid && in_ready;

  // Samples are left-justified in their slot; an empty holding register sends silence.
  always_comb begin
    left_slot  = '0;
    right_slot = '0;
    left_slot[SLOT_W-1 -: DATA_W]  = hold_left;
    right_slot[SLOT_W-1 -: DATA_W] = hold_right;
    frame_word = hold_full ? {left_slot, right_slot} : '0;
  end

  always_ff @(posedge state_clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) begin
        bclk <= ~bclk;
      end
    end
  end

  // sdata takes the old MSB, giving the one-BCLK delay after each lr_clk edge.
  always_ff @(posedge state_clk) begin
    if (!reset_n) begin
      bit_cnt     <= CNT_LAST;
      lr_clk      <= 1'b1;
      sdata       <= 1'b0;
      sr          <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= wrap;
      underrun    <= wrap && !hold_full;
      if (fall_evt) begin
        bit_cnt <= bit_cnt_nxt;
        lr_clk  <= (bit_cnt_nxt >= CNT_SLOT);
        sdata   <= sr[FRAME_W-1];
        sr      <= wrap ? frame_word : {sr[FRAME_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge state_clk) begin
    if (!reset_n) begin
      hold_full  <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
    end else if (wrap && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full  <= 1'b1;
      hold_left  <= in_left;
      hold_right <= in_right;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - scoreboard bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

  typedef struct packed {
    logic [63:0] word;
    logic        under;
  } frame_t;

  function automatic int sw_of(int g);
    return (g == 1) ? 16 : 32;
  endfunction

  function automatic int dv_of(int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstn_a     [3];
  logic [15:0] in_left_a  [3];
  logic [15:0] in_right_a [3];
  logic        in_valid_a [3];
  wire         in_ready_a [3];
  wire         bclk_a     [3];
  wire         lr_a       [3];
  wire         sdata_a    [3];
  wire         fs_a       [3];
  wire         under_a    [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int SW = sw_of(g);
    localparam int DV = dv_of(g);
    i2s_tx_serializer #(.DATA_W(16), .SLOT_W(SW), .BCLK_DIV(DV)) u_dut (
      .state_clk   (clk),
      .reset_n     (rstn_a[g]),
      .in_left     (in_left_a[g]),
      .in_right    (in_right_a[g]),
      .in_valid    (in_valid_a[g]),
      .in_ready    (in_ready_a[g]),
      .bclk        (bclk_a[g]),
      .lr_clk      (lr_a[g]),
      .sdata       (sdata_a[g]),
      .frame_start (fs_a[g]),
      .underrun    (under_a[g])
    );
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int g, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %0h expected %0h (cycle %0d)", name, g, act, exp, cyc);
    end
  endfunction

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  function automatic void push_exp(int g, logic [63:0] w, logic u);
    frame_t e;
    e.word  = w;
    e.under = u;
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t qpop(int g);
    case (g)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: each frame_start pops an expected frame; each bclk rise checks {lr_clk, sdata}.
  logic [63:0] cur       [3];
  logic        prev_lsb  [3];
  logic        prev_bclk [3];
  logic        have_cur  [3];
  logic        tail      [3];
  logic        first     [3];
  int          bit_j     [3];
  int          ref_cyc   [3];

  always @(negedge clk) begin
    frame_t     e;
    int         fw;
    logic [1:0] exp2;
    for (int g = 0; g < 3; g++) begin
      if (!rstn_a[g]) begin
        have_cur[g] = 1'b0;
        tail[g]     = 1'b0;
        cur[g]      = '0;
        first[g]    = 1'b1;
        ref_cyc[g]  = cyc + 1;
      end else begin
        if (g == 2 && !first[g])
          chk("bclk_toggle", g, 64'(bclk_a[g]), 64'(!prev_bclk[g]));
        if (under_a[g])
          chk("underrun_with_frame_start", g, 64'(fs_a[g]), 64'd1);
        if (fs_a[g]) begin
          chk("frame_period", g, 64'(cyc - ref_cyc[g]),
              64'(first[g] ? 2 * dv_of(g) : 4 * dv_of(g) * sw_of(g)));
          ref_cyc[g]  = cyc;
          first[g]    = 1'b0;
          prev_lsb[g] = cur[g][0];
          bit_j[g]    = 0;
          have_cur[g] = 1'b1;
          if (qsize(g) != 0) begin
            e = qpop(g);
            chk("underrun", g, 64'(under_a[g]), 64'(e.under));
            cur[g]  = e.word;
            tail[g] = 1'b0;
          end else begin
            cur[g]  = '0;
            tail[g] = 1'b1;
          end
        end
        if (have_cur[g] && bclk_a[g] && !prev_bclk[g]) begin
          fw      = 2 * sw_of(g);
          exp2[1] = (bit_j[g] >= sw_of(g));
          exp2[0] = (bit_j[g] == 0) ? prev_lsb[g] : cur[g][fw - bit_j[g]];
          chk($sformatf("lr_sdata_bit%0d", bit_j[g]), g, {62'd0, lr_a[g], sdata_a[g]}, {62'd0, exp2});
          bit_j[g] = bit_j[g] + 1;
          if (tail[g] || bit_j[g] == fw) have_cur[g] = 1'b0;
        end
      end
      prev_bclk[g] = bclk_a[g];
    end
  end

  task automatic wait_fs(input int g, output logic ready_seen);
    int n;
    n = 0;
    ready_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!fs_a[g] && in_ready_a[g]) ready_seen = 1'b1;
    end while (!fs_a[g] && n < 2000);
    chk("frame_start_seen", g, 64'(fs_a[g]), 64'd1);
  endtask

  task automatic send(input int g, input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    in_left_a[g]  = l;
    in_right_a[g] = r;
    in_valid_a[g] = 1'b1;
    while (!in_ready_a[g] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_ready", g, 64'(in_ready_a[g]), 64'd1);
    @(posedge clk);
    #1;
    in_valid_a[g] = 1'b0;
  endtask

  initial begin
    logic rdy;
    int   n;
    for (int g = 0; g < 3; g++) begin
      rstn_a[g]     = 1'b0;
      in_valid_a[g] = 1'b0;
      in_left_a[g]  = '0;
      in_right_a[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset_bclk", g, 64'(bclk_a[g]), 64'd0);
      chk("reset_lr_clk", g, 64'(lr_a[g]), 64'd1);
      chk("reset_in_ready", g, 64'(in_ready_a[g]), 64'd1);
    end

    push_exp(0, 64'hA5F0_0000_0F0F_0000, 1'b0);
    push_exp(0, 64'h0, 1'b1);
    push_exp(0, 64'h0, 1'b1);
    push_exp(0, 64'h0, 1'b1);
    push_exp(1, 64'h0000_0000_8001_8001, 1'b0);
    push_exp(1, 64'h0, 1'b1);
    push_exp(2, 64'hA5F0_0000_0F0F_0000, 1'b0);
    push_exp(2, 64'h0, 1'b1);
    in_left_a[0] = 16'hA5F0; in_right_a[0] = 16'h0F0F;
    in_left_a[1] = 16'h8001; in_right_a[1] = 16'h8001;
    in_left_a[2] = 16'hA5F0; in_right_a[2] = 16'h0F0F;
    for (int g = 0; g < 3; g++) begin
      in_valid_a[g] = 1'b1;
      rstn_a[g]     = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      in_valid_a[g] = 1'b0;
      chk("ready_low_after_push", g, 64'(in_ready_a[g]), 64'd0);
    end

    repeat (4) wait_fs(0, rdy);
    push_exp(0, 64'h1234_0000_5678_0000, 1'b0);
    send(0, 16'h1234, 16'h5678);
    wait_fs(0, rdy);
    chk("ready_low_while_held", 0, 64'(rdy), 64'd0);
    chk("ready_after_load", 0, 64'(in_ready_a[0]), 64'd1);
    push_exp(0, 64'h8000_0000_0001_0000, 1'b0);
    send(0, 16'h8000, 16'h0001);
    wait_fs(0, rdy);
    push_exp(0, 64'hFFFF_0000_7FFE_0000, 1'b0);
    send(0, 16'hFFFF, 16'h7FFE);
    wait_fs(0, rdy);
    send(0, 16'hDEAD, 16'hBEEF);

    n = 0;
    while (!lr_a[0] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("right_slot_reached", 0, 64'(lr_a[0]), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("pair_held_before_reset", 0, 64'(in_ready_a[0]), 64'd0);
    q0.delete();
    rstn_a[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_bclk", 0, 64'(bclk_a[0]), 64'd0);
    chk("midreset_lr_clk", 0, 64'(lr_a[0]), 64'd1);
    chk("midreset_sdata", 0, 64'(sdata_a[0]), 64'd0);
    chk("midreset_in_ready", 0, 64'(in_ready_a[0]), 64'd1);
    chk("midreset_frame_start", 0, 64'(fs_a[0]), 64'd0);
    chk("midreset_underrun", 0, 64'(under_a[0]), 64'd0);
    push_exp(0, 64'h0, 1'b1);
    push_exp(0, 64'h0, 1'b1);
    rstn_a[0] = 1'b1;
    repeat (3) wait_fs(0, rdy);
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
